// File: rtl/imem_pkg.sv
// imem_pkg: shared types and constants for the instruction-memory responder.
//   imem_state_e : responder FSM states (IDLE, WAIT, RESP)
//   NOP          : word returned in place of a faulting fetch (addi x0,x0,0)
//   CNT_W        : width of the wait-state counter (WAIT_CYCLES is 0..15)
//   word_in_range: true when a byte address selects a word below depth
package imem_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } imem_state_e;

  localparam logic [31:0] NOP   = 32'h0000_0013;
  localparam int          CNT_W = 4;

  function automatic logic word_in_range(input logic [31:0] byte_addr,
                                         input int unsigned depth);
    return ({2'b00, byte_addr[31:2]} < depth);
  endfunction

endpackage

// File: rtl/imem_array.sv
// imem_array: DEPTH x 32-bit instruction storage.
//   clk_i, rst_ni        : clock, async active-low reset (read register only)
//   rd_en_i, rd_idx_i    : synchronous read; rd_data_o updates only when enabled
//   rd_data_o            : registered read data, holds between reads
//   wr_en_i, wr_idx_i,
//   wr_data_i            : synchronous write port
// A read and a write to the same word on the same edge return the old word.
module imem_array #(
  parameter int DEPTH = 1024,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          rd_en_i,
  input  logic [AW-1:0] rd_idx_i,
  output logic [31:0]   rd_data_o,
  input  logic          wr_en_i,
  input  logic [AW-1:0] wr_idx_i,
  input  logic [31:0]   wr_data_i
);
  import imem_pkg::*;

  logic [31:0] mem_q [DEPTH];
  logic [31:0] rd_data_q, rd_data_d;

  // Storage is never reset; contents survive rst_ni.
  always_ff @(posedge clk_i) begin
    if (wr_en_i) mem_q[wr_idx_i] <= wr_data_i;
  end

  always_comb begin
    rd_data_d = rd_data_q;
    if (rd_en_i) rd_data_d = mem_q[rd_idx_i];
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) rd_data_q <= 32'h0;
    else         rd_data_q <= rd_data_d;
  end

  assign rd_data_o = rd_data_q;

endmodule

// File: rtl/imem_responder.sv
// imem_responder: instruction-memory responder for the fetch path.
//   clk_i, rst_ni       : clock, async active-low reset
//   req_valid_i/ready_o : fetch request handshake, req_addr_i is a byte address
//   rsp_valid_o/ready_i : response handshake, rsp_data_o/rsp_err_o held while stalled
//   ld_en_i/addr_i/data_i : load port, writes one word per cycle in any state
// Parameters: DEPTH (words, power of two >= 4), WAIT_CYCLES (0..15 wait states).
// Build option IMEM_ERR_CHECK_EN: when defined, misaligned or out-of-range
// fetches return NOP with rsp_err_o=1 and skip the array read; when undefined,
// addr[1:0] is ignored, the word index wraps modulo DEPTH and rsp_err_o is 0.
module imem_responder
  import imem_pkg::*;
#(
  parameter int DEPTH       = 1024,
  parameter int WAIT_CYCLES = 0
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        req_valid_i,
  input  logic [31:0] req_addr_i,
  output logic        req_ready_o,
  output logic        rsp_valid_o,
  input  logic        rsp_ready_i,
  output logic [31:0] rsp_data_o,
  output logic        rsp_err_o,
  input  logic        ld_en_i,
  input  logic [31:0] ld_addr_i,
  input  logic [31:0] ld_data_i
);

  localparam int              AW        = $clog2(DEPTH);
  localparam logic [1:0]      S_IDLE    = ST_IDLE;
  localparam logic [1:0]      S_WAIT    = ST_WAIT;
  localparam logic [1:0]      S_RESP    = ST_RESP;
  localparam logic [CNT_W-1:0] WAIT_INIT = CNT_W'(WAIT_CYCLES);

  logic [1:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [31:0]      addr_q, addr_d;
  logic             err_q, err_d;

  logic             accept;
  logic             enter_resp;
  logic [31:0]      rd_addr;
  logic             rd_err;
  logic             rd_en;
  logic [AW-1:0]    rd_idx;
  logic             wr_en;
  logic [31:0]      arr_data;
  logic             unused_addr_bits;

  // A stalled response blocks new requests; a completing one frees the slot
  // in the same cycle so fetches can stream back to back.
  assign req_ready_o = (state_q == S_IDLE) || ((state_q == S_RESP) && rsp_ready_i);
  assign accept      = req_valid_i && req_ready_o;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    addr_d     = addr_q;
    enter_resp = 1'b0;
    rd_addr    = addr_q;
    case (state_q)
      S_IDLE: state_d = S_IDLE;
      S_WAIT: begin
        if (cnt_q <= CNT_W'(1)) begin
          state_d    = S_RESP;
          enter_resp = 1'b1;
          cnt_d      = '0;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      S_RESP: if (rsp_ready_i) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    // With no wait states the array is read with the incoming address on the
    // same edge that captures it.
    if (accept) begin
      addr_d  = req_addr_i;
      rd_addr = req_addr_i;
      if (WAIT_CYCLES == 0) begin
        state_d    = S_RESP;
        enter_resp = 1'b1;
      end else begin
        state_d = S_WAIT;
        cnt_d   = WAIT_INIT;
      end
    end
  end

`ifdef IMEM_ERR_CHECK_EN
  assign rd_err = (rd_addr[1:0] != 2'b00) || !word_in_range(rd_addr, DEPTH);
`else
  assign rd_err = 1'b0;
`endif

  assign rd_idx = rd_addr[2 +: AW];
  assign rd_en  = enter_resp && !rd_err;
  assign err_d  = enter_resp ? rd_err : err_q;
  assign wr_en  = ld_en_i && word_in_range(ld_addr_i, DEPTH);

  assign unused_addr_bits = ^{ld_addr_i[1:0], rd_addr};

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
    end
  end

  always_ff @(posedge clk_i) begin
    addr_q <= addr_d;
  end

  imem_array #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_array (
    .clk_i     (clk_i),
    .rst_ni    (rst_ni),
    .rd_en_i   (rd_en),
    .rd_idx_i  (rd_idx),
    .rd_data_o (arr_data),
    .wr_en_i   (wr_en),
    .wr_idx_i  (ld_addr_i[2 +: AW]),
    .wr_data_i (ld_data_i)
  );

  assign rsp_valid_o = (state_q == S_RESP);
  assign rsp_err_o   = err_q;
  assign rsp_data_o  = err_q ? NOP : arr_data;

endmodule

// File: tb/tb_imem_responder.sv
module tb_imem_responder;

  localparam int unsigned DEPTH = 1024;
  localparam logic [31:0] NOP_W = 32'h0000_0013;

  logic        clk;
  logic        rst_n;
  logic        ld_en;
  logic [31:0] ld_addr, ld_data;

  logic        req_valid0, req_ready0, rsp_valid0, rsp_ready0, rsp_err0;
  logic [31:0] req_addr0, rsp_data0;
  logic        req_valid3, req_ready3, rsp_valid3, rsp_ready3, rsp_err3;
  logic [31:0] req_addr3, rsp_data3;

  int          total = 0;
  int          bad   = 0;
  logic [31:0] mem_m [DEPTH];
  logic [32:0] q0 [$];
  logic        last_acc0, last_rdy0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  imem_responder #(.DEPTH(1024), .WAIT_CYCLES(0)) u_dut0 (
    .clk_i(clk), .rst_ni(rst_n),
    .req_valid_i(req_valid0), .req_addr_i(req_addr0), .req_ready_o(req_ready0),
    .rsp_valid_o(rsp_valid0), .rsp_ready_i(rsp_ready0), .rsp_data_o(rsp_data0),
    .rsp_err_o(rsp_err0),
    .ld_en_i(ld_en), .ld_addr_i(ld_addr), .ld_data_i(ld_data)
  );

  imem_responder #(.DEPTH(1024), .WAIT_CYCLES(3)) u_dut3 (
    .clk_i(clk), .rst_ni(rst_n),
    .req_valid_i(req_valid3), .req_addr_i(req_addr3), .req_ready_o(req_ready3),
    .rsp_valid_o(rsp_valid3), .rsp_ready_i(rsp_ready3), .rsp_data_o(rsp_data3),
    .rsp_err_o(rsp_err3),
    .ld_en_i(ld_en), .ld_addr_i(ld_addr), .ld_data_i(ld_data)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Reference answer for a fetch: {err, data}.
  function automatic logic [32:0] exp_rsp(input logic [31:0] a);
    int unsigned w;
    w = a >> 2;
`ifdef IMEM_ERR_CHECK_EN
    if ((a % 4) != 0 || w >= DEPTH) return {1'b1, NOP_W};
`endif
    return {1'b0, mem_m[w % DEPTH]};
  endfunction

  // One cycle on the zero-wait DUT; also drives the shared load port.
  task automatic step0(input logic v, input logic [31:0] a, input logic rr,
                       input logic le, input logic [31:0] la, input logic [31:0] ldat);
    logic [32:0] e;
    @(negedge clk);
    req_valid0 = v; req_addr0 = a; rsp_ready0 = rr;
    ld_en = le; ld_addr = la; ld_data = ldat;
    #1;
    chk("vld0", 32'(rsp_valid0), 32'(q0.size() > 0));
    if (rsp_valid0 && q0.size() > 0) begin
      e = q0[0];
      chk("rsp0_data", rsp_data0, e[31:0]);
      chk("rsp0_err", 32'(rsp_err0), 32'(e[32]));
      if (rr) void'(q0.pop_front());
    end
    last_rdy0 = req_ready0;
    last_acc0 = v && req_ready0;
    if (last_acc0) q0.push_back(exp_rsp(a));
    if (le && (la >> 2) < DEPTH) mem_m[(la >> 2) % DEPTH] = ldat;
  endtask

  task automatic req0(input logic [31:0] a, input logic rr);
    step0(1'b1, a, rr, 1'b0, 32'h0, 32'h0);
  endtask

  task automatic idle0();
    step0(1'b0, 32'h0, 1'b1, 1'b0, 32'h0, 32'h0);
  endtask

  initial begin
    logic [32:0] e;
    logic        pv, got;
    logic [31:0] pa;
    int          n;

    rst_n = 1'b0; ld_en = 1'b0; ld_addr = '0; ld_data = '0;
    req_valid0 = 1'b0; req_addr0 = '0; rsp_ready0 = 1'b1;
    req_valid3 = 1'b0; req_addr3 = '0; rsp_ready3 = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("rst0_rdy",  32'(req_ready0), 32'd1);
    chk("rst0_vld",  32'(rsp_valid0), 32'd0);
    chk("rst0_data", rsp_data0, 32'h0);
    chk("rst0_err",  32'(rsp_err0), 32'd0);
    chk("rst3_rdy",  32'(req_ready3), 32'd1);
    chk("rst3_vld",  32'(rsp_valid3), 32'd0);
    chk("rst3_data", rsp_data3, 32'h0);

    // Preload words 0..15 with random data, then the named pattern.
    for (int i = 0; i < 16; i++) step0(1'b0, 0, 1'b1, 1'b1, 32'(i * 4), $urandom);
    step0(1'b0, 0, 1'b1, 1'b1, 32'h0, 32'd11);
    step0(1'b0, 0, 1'b1, 1'b1, 32'h4, 32'd22);
    step0(1'b0, 0, 1'b1, 1'b1, 32'h8, 32'd33);
    step0(1'b0, 0, 1'b1, 1'b1, 32'hC, 32'd44);
    // Out-of-range load must not disturb word 0 (which 0x1000 aliases to).
    step0(1'b0, 0, 1'b1, 1'b1, 32'h1000, 32'hDEAD_BEEF);

    // Back-to-back zero-wait fetches.
    req0(32'h0, 1'b1); chk("b2b_acc0", 32'(last_acc0), 32'd1);
    req0(32'h4, 1'b1); chk("b2b_acc1", 32'(last_acc0), 32'd1);
    req0(32'h8, 1'b1); chk("b2b_acc2", 32'(last_acc0), 32'd1);
    idle0(); idle0();

    // Misaligned and out-of-range fetches.
    req0(32'h6, 1'b1);
    req0(32'h1000, 1'b1);
    idle0(); idle0();

    // Load to word 1 on the same edge that captures a fetch of word 1.
    step0(1'b1, 32'h4, 1'b1, 1'b1, 32'h4, 32'h55);
    req0(32'h4, 1'b1);
    idle0(); idle0();

    // Stalled response blocks a waiting request.
    req0(32'h8, 1'b0); chk("stall_acc_first", 32'(last_acc0), 32'd1);
    req0(32'hC, 1'b0); chk("stall_rdy_a", 32'(last_rdy0), 32'd0);
    req0(32'hC, 1'b0); chk("stall_rdy_b", 32'(last_rdy0), 32'd0);
    req0(32'hC, 1'b1); chk("stall_acc_release", 32'(last_acc0), 32'd1);
    idle0(); idle0(); idle0();

    // Three wait states, then a response held for five stalled cycles.
    e = exp_rsp(32'hC);
    @(negedge clk); req_valid3 = 1'b1; req_addr3 = 32'hC; rsp_ready3 = 1'b0;
    #1 chk("w3_rdy_idle", 32'(req_ready3), 32'd1);
    @(negedge clk); req_valid3 = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("w3_rdy_wait", 32'(req_ready3), 32'd0);
      chk("w3_vld_wait", 32'(rsp_valid3), 32'd0);
      @(negedge clk);
    end
    for (int i = 0; i < 5; i++) begin
      #1;
      chk("w3_vld_hold", 32'(rsp_valid3), 32'd1);
      chk("w3_data_hold", rsp_data3, e[31:0]);
      chk("w3_err_hold", 32'(rsp_err3), 32'(e[32]));
      @(negedge clk);
    end
    rsp_ready3 = 1'b1;
    #1 chk("w3_rdy_release", 32'(req_ready3), 32'd1);
    @(negedge clk); rsp_ready3 = 1'b0;
    #1;
    chk("w3_idle_vld", 32'(rsp_valid3), 32'd0);
    chk("w3_idle_rdy", 32'(req_ready3), 32'd1);

    // Reset while waiting drops the fetch.
    @(negedge clk); req_valid3 = 1'b1; req_addr3 = 32'h8;
    @(negedge clk); req_valid3 = 1'b0;
    @(negedge clk); rst_n = 1'b0;
    #1 chk("rstw_vld", 32'(rsp_valid3), 32'd0);
    @(negedge clk); rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      #1;
      chk("rstw_no_rsp", 32'(rsp_valid3), 32'd0);
      chk("rstw_rdy", 32'(req_ready3), 32'd1);
      @(negedge clk);
    end
    e = exp_rsp(32'h4);
    req_valid3 = 1'b1; req_addr3 = 32'h4; rsp_ready3 = 1'b1;
    @(negedge clk); req_valid3 = 1'b0;
    got = 1'b0; n = 0;
    for (int i = 0; i < 10 && !got; i++) begin
      #1;
      if (rsp_valid3) got = 1'b1;
      else begin n++; @(negedge clk); end
    end
    chk("rstw_seen", 32'(got), 32'd1);
    chk("rstw_lat", 32'(n), 32'd3);
    chk("rstw_data", rsp_data3, e[31:0]);
    chk("rstw_err", 32'(rsp_err3), 32'(e[32]));
    @(negedge clk); rsp_ready3 = 1'b0;

    // Randomized traffic on the zero-wait responder.
    pv = 1'b0; pa = '0;
    for (int i = 0; i < 400; i++) begin
      logic rr, le;
      logic [31:0] la;
      if (!pv && $urandom_range(0, 3) != 0) begin
        pv = 1'b1;
        case ($urandom_range(0, 5))
          0:       pa = 32'(32'h1000 + $urandom_range(0, 15) * 4);
          1:       pa = 32'($urandom_range(0, 15) * 4 + $urandom_range(1, 3));
          default: pa = 32'($urandom_range(0, 15) * 4);
        endcase
      end
      rr = ($urandom_range(0, 3) != 0);
      le = ($urandom_range(0, 3) == 0);
      la = ($urandom_range(0, 7) == 0) ? 32'h2000 : 32'($urandom_range(0, 15) * 4);
      step0(pv, pa, rr, le, la, $urandom);
      if (last_acc0) pv = 1'b0;
    end
    idle0(); idle0(); idle0();
    chk("drain_empty", 32'(q0.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
